// File: rtl/blankport_sweep.sv
// Exhaustive operand sweep around a WIDTH-bit bitwise-AND block.
// Drives a/b from the vector index and checks o against a & b after SETTLE cycles.
module blankport_sweep #(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [WIDTH-1:0]     a,
  output logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     o,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH:0]     err_count,
  output logic                 fail_seen,
  output logic [WIDTH-1:0]     first_fail_a,
  output logic [WIDTH-1:0]     first_fail_b
);

  localparam int IW = 2 * WIDTH;
  localparam int EW = IW + 1;
  localparam int CW = 4;

  localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [EW-1:0] ERR_ONE  = EW'(1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    SAMPLE,
    DONE
  } state_t;

  state_t         state;
  logic [IW-1:0]  idx;
  logic [CW-1:0]  cnt;

  logic           mism;
  logic [EW-1:0]  err_next;
  logic [IW-1:0]  idx_next;

  // Case inequality so an unknown result from the block counts as a failure.
  always_comb begin
    mism     = (o !== (a & b));
    err_next = err_count + (mism ? ERR_ONE : '0);
    idx_next = idx + IDX_ONE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      cnt          <= '0;
      a            <= '0;
      b            <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_count    <= '0;
      fail_seen    <= 1'b0;
      first_fail_a <= '0;
      first_fail_b <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            idx          <= '0;
            a            <= '0;
            b            <= '0;
            err_count    <= '0;
            fail_seen    <= 1'b0;
            first_fail_a <= '0;
            first_fail_b <= '0;
            cnt          <= SETTLE_C;
            busy         <= 1'b1;
            done         <= 1'b0;
            pass         <= 1'b0;
            state        <= (SETTLE == 0) ? SAMPLE : HOLD;
          end
        end

        HOLD: begin
          cnt <= cnt - CNT_ONE;
          if (cnt <= CNT_ONE) begin
            state <= SAMPLE;
          end
        end

        SAMPLE: begin
          err_count <= err_next;
          if (mism) begin
            fail_seen <= 1'b1;
            if (!fail_seen) begin
              first_fail_a <= a;
              first_fail_b <= b;
            end
          end
          if (idx == '1) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            idx   <= idx_next;
            a     <= idx_next[IW-1:WIDTH];
            b     <= idx_next[WIDTH-1:0];
            cnt   <= SETTLE_C;
            state <= (SETTLE == 0) ? SAMPLE : HOLD;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_blankport_sweep.sv
// Scoreboard bench for blankport_sweep: stimulus queues expected sweep results,
// a monitor pops and compares them whenever done rises.
module tb_blankport_sweep;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] a, b, o;
  logic       busy, done, pass, fail_seen;
  logic [4:0] err_count;
  logic [1:0] first_fail_a, first_fail_b;

  int mode = 0;  // 0: a&b, 1: stuck 0, 2: a|b

  always #5 clk = ~clk;

  always_comb begin
    case (mode)
      1:       o = 2'b00;
      2:       o = a | b;
      default: o = a & b;
    endcase
  end

  blankport_sweep #(.WIDTH(2), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a), .b(b), .o(o),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_seen(fail_seen),
    .first_fail_a(first_fail_a), .first_fail_b(first_fail_b)
  );

  typedef struct {
    logic [4:0] err;
    logic       pass;
    logic       fs;
    logic [1:0] fa;
    logic [1:0] fb;
    int         cycles;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, req);
  endtask

  task automatic push(input logic [4:0] err, input logic p, input logic fs,
                      input logic [1:0] fa, input logic [1:0] fb);
    exp_t e;
    e.err = err; e.pass = p; e.fs = fs; e.fa = fa; e.fb = fb; e.cycles = 32;
    exp_q.push_back(e);
  endtask

  // Monitor: samples 1 time unit after each rising edge, stimulus drives on falling edges.
  int   busy_cycles = 0;
  logic done_q = 1'b0;
  always begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      busy_cycles = 0;
      done_q      = 1'b0;
    end else begin
      if (busy) busy_cycles++;
      if (done && !done_q) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("busy_cycles",  busy_cycles,  e.cycles);
          check("err_count",    err_count,    e.err);
          check("pass",         pass,         e.pass);
          check("fail_seen",    fail_seen,    e.fs);
          check("first_fail_a", first_fail_a, e.fa);
          check("first_fail_b", first_fail_b, e.fb);
        end
        busy_cycles = 0;
      end
      done_q = done;
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done) break;
    end
    if (k == 200) check("done_timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  int extra_k;

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {a, b, busy, done, pass, err_count, fail_seen, first_fail_a, first_fail_b}, 0);
    rst_n = 1'b1;

    // Correct DUT
    mode = 0; push(5'd0, 1'b1, 1'b0, 2'b00, 2'b00);
    pulse_start(); wait_done();

    // Stuck-at-zero result: 7 vectors have a&b != 0, first is a=1,b=1
    mode = 1; push(5'd7, 1'b0, 1'b1, 2'b01, 2'b01);
    pulse_start(); wait_done();

    // Wrong operator a|b: 12 vectors with a != b, first is a=0,b=1
    mode = 2; push(5'd12, 1'b0, 1'b1, 2'b00, 2'b01);
    pulse_start(); wait_done();

    // Extra start pulses at cycles 5 and 20 of a sweep are ignored
    mode = 0; push(5'd0, 1'b1, 1'b0, 2'b00, 2'b00);
    pulse_start();
    repeat (4) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (14) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_done();

    // Reset mid-sweep at idx=9 (a=2,b=1)
    mode = 1;
    pulse_start();
    for (extra_k = 0; extra_k < 100; extra_k++) begin
      if (a == 2'b10 && b == 2'b01) break;
      @(negedge clk);
    end
    check("reach_idx9", extra_k < 100, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midsweep_reset_outputs",
          {a, b, busy, done, pass, err_count, fail_seen, first_fail_a, first_fail_b}, 0);
    mode = 0; push(5'd0, 1'b1, 1'b0, 2'b00, 2'b00);
    pulse_start(); wait_done();

    // Back to back: failing then correct, restarting from DONE
    mode = 1; push(5'd7, 1'b0, 1'b1, 2'b01, 2'b01);
    pulse_start(); wait_done();
    mode = 0; push(5'd0, 1'b1, 1'b0, 2'b00, 2'b00);
    check("done_before_restart", done, 1);
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    check("done_drops", done, 0);
    @(negedge clk) start = 1'b0;
    wait_done();

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
